seg7_scanner: RTL and testbench
===============================

SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000, giving the clock cycles per digit slot; legal range 4..65535.
REQ-002 The block SHALL have parameter BLANK, default 4, giving the anode-off cycles at the start of each slot; legal only when BLANK < PRESCALE.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous, active-high reset.
REQ-005 The block SHALL have port value, input, 16, the display word from the GPIO output mux; nibble k drives digit k, and digit 0 is the rightmost.
REQ-006 The block SHALL have port load, input, 1, a request to capture value.
REQ-007 The block SHALL have port blank_lz, input, 1, the leading-zero blanking enable.
REQ-008 The block SHALL have port dp_in, input, 4, the per-digit decimal-point enables; these are not shadowed and are sampled live.
REQ-009 The block SHALL have port anode, output, 4, the active-low digit enables; bit k enables digit k.
REQ-010 The block SHALL have port cathode, output, 7, the active-low segments ordered {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port dp, output, 1, the active-low decimal point.
REQ-012 The block SHALL have port frame, output, 1, a one-cycle pulse on each digit 3->0 wrap.

Function
REQ-013 The prescale counter cnt SHALL count 0..PRESCALE-1 and wrap to 0; the cycle where cnt=PRESCALE-1 is the slot tick.
REQ-014 On a slot tick, digit index dig SHALL advance 0->1->2->3->0.
REQ-015 On a tick where dig=3, frame SHALL assert in the following cycle, for exactly one cycle.
REQ-016 A cycle with load=1 SHALL write value into pending register pend and set pend_v=1.
REQ-017 On each 3->0 wrap, display register disp SHALL load the transfer source: value if load=1 that cycle, else pend if pend_v=1, else disp is held.
REQ-018 pend_v SHALL clear on a 3->0 wrap unless load=1 that cycle, in which case pend_v SHALL remain set.
REQ-019 disp SHALL change only at frame boundaries, so no frame ever shows a torn mix of old and new digits.
REQ-020 anode, cathode and dp SHALL be registered and updated on the same edge as cnt and dig, reflecting the post-edge cnt, dig and disp.
REQ-021 anode SHALL be 4'hF while cnt < BLANK, or while the current digit is blanked; otherwise it SHALL be ~(4'b0001 << dig).
REQ-022 cathode SHALL be the hex decode of disp nibble dig, with 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 cathode SHALL be 7'h7F whenever anode is 4'hF.
REQ-024 dp SHALL equal ~dp_in[dig] when the digit is lit, else 1.
REQ-025 With blank_lz=1, digit k (k=1..3) SHALL be blanked when disp[15:4k] is all zero; digit 0 is never blanked.
REQ-026 blank_lz and dp_in changes SHALL take effect on the next edge without waiting for a frame boundary.
REQ-027 load held high continuously SHALL be legal: disp takes the value present at each wrap edge.

Reset
REQ-028 reset SHALL asynchronously force cnt=0, dig=0, disp=0, pend=0, pend_v=0, anode=4'hF, cathode=7'h7F, dp=1 and frame=0.
REQ-029 An assertion of reset mid-slot or mid-frame SHALL discard any pending load.
REQ-030 After reset deasserts, the first slot SHALL be digit 0, blanked for BLANK cycles and then showing '0'.

Verification (PRESCALE=8, BLANK=2)
REQ-031 Reset release with value=0 and load=0: anode=F for 2 cycles, then E with cathode 1000000 for 6 cycles; then slots D, B, 7 in turn; frame pulses once every 32 cycles.
REQ-032 load=1 for one cycle with value=16'h12AF mid-frame: the display is unchanged until the next wrap; the following frame shows digits F, A, 2, 1 on anodes E, D, B, 7 with cathodes 0001110, 0001000, 0100100, 1111001.
REQ-033 Load 16'h1111 then 16'h2222 in the same frame: only 2222 is displayed; with load=1 coincident with the wrap edge and value=16'h0003, disp=0003 and pend_v=1.
REQ-034 blank_lz=1 with disp=16'h0040: digits 3 and 2 keep anode F for their full slots, digit 1 shows '4', digit 0 shows '0'; with disp=0, only digit 0 is lit.
REQ-035 dp_in=4'b0100: dp=0 only during digit 2's lit cycles and 1 during its blank cycles.
REQ-036 reset asserted mid-slot of digit 2 with pend_v=1: the outputs go to reset values immediately without a clock, and the old disp/pend are not shown after release.

Source files
------------

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous display update,
// per-slot anode blanking, leading-zero suppression and live decimal points.
module seg7_scanner #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame
);

  localparam logic [15:0] LP_CNT_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0] LP_BLANK   = 16'(BLANK);

  logic [15:0] r_cnt;
  logic [1:0]  r_dig;
  logic [15:0] r_disp;
  logic [15:0] r_pend;
  logic        r_pend_v;
  logic [3:0]  r_anode;
  logic [6:0]  r_cathode;
  logic        r_dp;
  logic        r_frame;

  logic        w_tick;
  logic        w_wrap;
  logic [15:0] w_cnt_n;
  logic [1:0]  w_dig_n;
  logic [15:0] w_disp_n;
  logic [3:0]  w_nib;
  logic        w_lz_blank;
  logic        w_lit;
  logic [6:0]  w_seg;
  logic [3:0]  w_anode_n;
  logic [6:0]  w_cathode_n;
  logic        w_dp_n;

  assign w_tick  = (r_cnt == LP_CNT_MAX);
  assign w_wrap  = w_tick && (r_dig == 2'd3);
  assign w_cnt_n = w_tick ? 16'd0 : r_cnt + 16'd1;
  assign w_dig_n = w_tick ? r_dig + 2'd1 : r_dig;

  // A load coinciding with the wrap edge bypasses pend so the newest word wins.
  always_comb begin
    w_disp_n = r_disp;
    if (w_wrap) begin
      if (load)
        w_disp_n = value;
      else if (r_pend_v)
        w_disp_n = r_pend;
    end
  end

  // Outputs are decoded from post-edge state so they line up with cnt/dig/disp.
  always_comb begin
    w_nib      = 4'h0;
    w_lz_blank = 1'b0;
    case (w_dig_n)
      2'd0: w_nib = w_disp_n[3:0];
      2'd1: begin
        w_nib      = w_disp_n[7:4];
        w_lz_blank = blank_lz && (w_disp_n[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib      = w_disp_n[11:8];
        w_lz_blank = blank_lz && (w_disp_n[15:8] == 8'h00);
      end
      default: begin
        w_nib      = w_disp_n[15:12];
        w_lz_blank = blank_lz && (w_disp_n[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

  assign w_lit       = (w_cnt_n >= LP_BLANK) && !w_lz_blank;
  assign w_anode_n   = w_lit ? ~(4'b0001 << w_dig_n) : 4'hF;
  assign w_cathode_n = w_lit ? w_seg : 7'h7F;
  assign w_dp_n      = w_lit ? ~dp_in[w_dig_n] : 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= 16'd0;
      r_dig     <= 2'd0;
      r_disp    <= 16'h0000;
      r_pend    <= 16'h0000;
      r_pend_v  <= 1'b0;
      r_anode   <= 4'hF;
      r_cathode <= 7'h7F;
      r_dp      <= 1'b1;
      r_frame   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_dig     <= w_dig_n;
      r_disp    <= w_disp_n;
      r_frame   <= w_wrap;
      r_anode   <= w_anode_n;
      r_cathode <= w_cathode_n;
      r_dp      <= w_dp_n;
      if (load) begin
        r_pend   <= value;
        r_pend_v <= 1'b1;
      end else if (w_wrap) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign anode   = r_anode;
  assign cathode = r_cathode;
  assign dp      = r_dp;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner: outputs compared every cycle against a
// time-based model (slot/digit derived from cycles since reset release).
module tb_seg7_scanner;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * P;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame;

  int tests = 0;
  int fails = 0;

  int          m_t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pv = 1'b0;
  logic        m_blz = 1'b0;
  logic [3:0]  m_dpi = 4'h0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scanner #(.PRESCALE(P), .BLANK(B)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .blank_lz(blank_lz), .dp_in(dp_in), .anode(anode),
    .cathode(cathode), .dp(dp), .frame(frame));

  always #5 clock = ~clock;

  // Expected {anode, cathode, dp, frame} for the current model time.
  function automatic logic [12:0] expected();
    int cnt, dig;
    bit lit;
    logic [3:0] nib;
    logic [3:0] an;
    cnt = m_t % P;
    dig = (m_t / P) % 4;
    nib = 4'((m_disp >> (4 * dig)) & 16'h000F);
    lit = (cnt >= B) && !(m_blz && dig > 0 && (m_disp >> (4 * dig)) == 16'h0000);
    an  = 4'hF ^ 4'(1 << dig);
    return {lit ? an : 4'hF, lit ? seg_tbl[nib] : 7'h7F,
            lit ? ~m_dpi[dig] : 1'b1, (m_t > 0) && (m_t % FR == 0)};
  endfunction

  task automatic step();
    bit wrap;
    @(posedge clock);
    wrap = (m_t % FR) == FR - 1;
    if (wrap) begin
      if (load) m_disp = value;
      else if (m_pv) m_disp = m_pend;
    end
    if (load) begin
      m_pend = value;
      m_pv = 1'b1;
    end else if (wrap) begin
      m_pv = 1'b0;
    end
    m_blz = blank_lz;
    m_dpi = dp_in;
    m_t++;
    @(negedge clock);
  endtask

  task automatic model_reset();
    m_t = 0; m_disp = 16'h0000; m_pend = 16'h0000; m_pv = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++; if (anode !== 4'hF) begin fails++; $display("FAIL reset_anode got=%h exp=F", anode); end
    tests++; if (cathode !== 7'h7F) begin fails++; $display("FAIL reset_cathode got=%h exp=7f", cathode); end
    tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", dp); end
    tests++; if (frame !== 1'b0) begin fails++; $display("FAIL reset_frame got=%b exp=0", frame); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_scan();
    int frames = 0;
    int e_lit = 0;
    value = 16'h0000; load = 1'b0;
    repeat (2 * FR) begin
      step();
      if (frame === 1'b1) frames++;
      if (m_t <= P && anode === 4'hE && cathode === 7'b1000000) e_lit++;
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL scan t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    tests++; if (frames != 2) begin fails++; $display("FAIL scan_frames got=%0d exp=2", frames); end
    tests++; if (e_lit != P - B) begin fails++; $display("FAIL scan_first_slot got=%0d exp=%0d", e_lit, P - B); end
  endtask

  task automatic test_load();
    while (m_t % FR != 10) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL load_pre t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    value = 16'h12AF; load = 1'b1;
    step();
    load = 1'b0; value = 16'h0000;
    repeat (FR + FR) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL load t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
      if (m_t % FR == 3 && m_disp == 16'h12AF) begin
        tests++;
        if (cathode !== 7'b0001110 || anode !== 4'hE) begin
          fails++; $display("FAIL load_digit0 got=%h/%h exp=E/0e", anode, cathode);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    while (m_t % FR != 5) step();
    value = 16'h1111; load = 1'b1; step();
    load = 1'b0; step(); step();
    value = 16'h2222; load = 1'b1; step();
    load = 1'b0;
    while (m_t % FR != FR - 1) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL b2b_a t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    value = 16'h0003; load = 1'b1;
    step();
    load = 1'b0; value = 16'h0000;
    repeat (2 * FR) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL b2b_b t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
  endtask

  task automatic test_blank_lz();
    int hi_lit = 0;
    value = 16'h0040; load = 1'b1; step();
    load = 1'b0;
    while (m_t % FR != 0) step();
    blank_lz = 1'b1;
    repeat (FR) begin
      step();
      if (((m_t / P) % 4) >= 2 && anode !== 4'hF) hi_lit++;
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL lz t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    tests++; if (hi_lit != 0) begin fails++; $display("FAIL lz_upper_lit got=%0d exp=0", hi_lit); end
    value = 16'h0000; load = 1'b1; step();
    load = 1'b0;
    repeat (2 * FR) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL lz_zero t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp();
    int dp_low = 0;
    dp_in = 4'b0100;
    step();
    repeat (FR) begin
      step();
      if (dp === 1'b0) dp_low++;
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL dp t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    tests++; if (dp_low != P - B) begin fails++; $display("FAIL dp_count got=%0d exp=%0d", dp_low, P - B); end
    dp_in = 4'h0;
  endtask

  task automatic test_random();
    repeat (600) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL rand t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
    load = 1'b0; blank_lz = 1'b0; dp_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    while (m_t % FR != 2 * P + 1) step();
    value = 16'h9876; load = 1'b1; step();
    load = 1'b0;
    while (m_t % FR != 2 * P + 4) step();
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({anode, cathode, dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_async got=%h exp=%h", {anode, cathode, dp, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (2 * FR + 4) begin
      step();
      tests++;
      if ({anode, cathode, dp, frame} !== expected()) begin
        fails++; $display("FAIL reset_mid t=%0d got=%h exp=%h", m_t, {anode, cathode, dp, frame}, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_blank_lz();
    test_dp();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
